// File: rtl/bp_nonsynth_resp_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_nonsynth_resp_checker_if
// Purpose  : Bundles the DUT-response side and the trace-replay side of the
//            response checker into one interface.
//            master = bench / trace-replay side, slave = checker.
// Signals  : data_v_i/data_i/ready_o   per-channel response beats and flow control
//            expect_v_i/expect_data_i/expect_chan_i/expect_yumi_o
//                                      expected-beat stream and consume strobe
//            match_count_o/mismatch_count_o/error_o
//                                      check results
// Revision : 1.0 - initial release
// ============================================================================
interface bp_nonsynth_resp_checker_if #(
    parameter int width_p    = 32,
    parameter int channels_p = 1
);
    localparam int c_chan_w = (channels_p > 1) ? $clog2(channels_p) : 1;

    logic [channels_p-1:0]         data_v_i;
    logic [channels_p*width_p-1:0] data_i;
    logic [channels_p-1:0]         ready_o;
    logic                          expect_v_i;
    logic [width_p-1:0]            expect_data_i;
    logic [c_chan_w-1:0]           expect_chan_i;
    logic                          expect_yumi_o;
    logic [31:0]                   match_count_o;
    logic [31:0]                   mismatch_count_o;
    logic                          error_o;

    modport master (
        output data_v_i, data_i, expect_v_i, expect_data_i, expect_chan_i,
        input  ready_o, expect_yumi_o, match_count_o, mismatch_count_o, error_o
    );

    modport slave (
        input  data_v_i, data_i, expect_v_i, expect_data_i, expect_chan_i,
        output ready_o, expect_yumi_o, match_count_o, mismatch_count_o, error_o
    );
endinterface
`default_nettype wire

// File: rtl/bp_nonsynth_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : bp_nonsynth_resp_checker
// Purpose  : Multi-channel response buffer and in-order checker. Each channel
//            buffers DUT beats in a FIFO drained by an LFSR-randomised
//            consumer; every popped beat is compared with the expected stream.
// Ports    : clk_i    - clock
//            reset_i  - asynchronous active-high reset
//            bus      - bp_nonsynth_resp_checker_if.slave (beats, expected
//                       stream, match/mismatch counts, sticky error)
// Options  : BP_RESP_CHECKER_WATCHDOG_EN - adds a stall watchdog that sets
//            error_o when an expected beat waits timeout_cycles_p cycles.
// Revision : 1.0 - initial release
// ============================================================================
module bp_nonsynth_resp_checker #(
    parameter int          width_p          = 32,
    parameter int          els_p            = 16,
    parameter int          channels_p       = 1,
    parameter int          yumi_min_delay_p = 0,
    parameter int          yumi_max_delay_p = 15,
    parameter logic [15:0] seed_p           = 16'hACE1,
    parameter int          timeout_cycles_p = 1024
) (
    input  wire logic                    clk_i,
    input  wire logic                    reset_i,
    bp_nonsynth_resp_checker_if.slave    bus
);
    localparam int          c_ptr_w   = $clog2(els_p);
    localparam int          c_cnt_w   = c_ptr_w + 1;
    localparam logic [31:0] c_min     = 32'(yumi_min_delay_p);
    localparam logic [31:0] c_range   = 32'(yumi_max_delay_p - yumi_min_delay_p + 1);
    localparam logic [15:0] c_lfsr_tp = 16'hB400; // x^16+x^14+x^13+x^11+1

    typedef enum logic [0:0] {
        ST_WAIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    logic [channels_p-1:0] w_pop_vec;
    logic [width_p-1:0]    w_head [channels_p];
    logic [width_p-1:0]    w_pop_data;
    logic                  w_pop_any;
    logic                  w_beat_eq;
    logic                  w_wd_err;
    logic [31:0]           r_match;
    logic [31:0]           r_mismatch;
    logic                  r_err;

    for (genvar c = 0; c < channels_p; c++) begin : g_chan
        localparam logic [15:0] c_seed_raw = seed_p ^ 16'(c);
        localparam logic [15:0] c_seed     = (c_seed_raw == 16'h0) ? 16'h1 : c_seed_raw;

        logic [width_p-1:0] r_mem [els_p];
        logic [c_ptr_w-1:0] r_wptr;
        logic [c_ptr_w-1:0] r_rptr;
        logic [c_cnt_w-1:0] r_occ;
        state_e             r_state;
        logic [15:0]        r_lfsr;
        logic [31:0]        r_delay;
        logic               w_full;
        logic               w_empty;
        logic               w_enq;
        logic               w_sel;
        logic               w_pop;
        logic [31:0]        w_reload;

        assign w_full   = (r_occ == c_cnt_w'(els_p));
        assign w_empty  = (r_occ == '0);
        assign w_enq    = bus.data_v_i[c] & ~w_full;
        assign w_sel    = bus.expect_v_i & (32'(bus.expect_chan_i) == 32'(c));
        // A zero delay lets the head beat pop while still nominally in WAIT,
        // which gives the one-cycle first-word latency with min delay 0.
        assign w_pop    = w_sel & ~w_empty & ((r_state == ST_READY) || (r_delay == 32'd0));
        assign w_reload = c_min + (32'(r_lfsr) % c_range);

        assign bus.ready_o[c] = ~w_full;
        assign w_pop_vec[c]   = w_pop;
        assign w_head[c]      = r_mem[r_rptr];

        // Storage carries no reset; emptiness is defined by the pointers.
        always_ff @(posedge clk_i) begin
            if (w_enq) begin
                r_mem[r_wptr] <= bus.data_i[c*width_p +: width_p];
            end
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_occ   <= '0;
                r_state <= ST_WAIT;
                r_lfsr  <= c_seed;
                r_delay <= c_min;
            end else begin
                if (w_enq) r_wptr <= r_wptr + 1'b1;
                if (w_pop) r_rptr <= r_rptr + 1'b1;
                r_occ <= r_occ + c_cnt_w'(w_enq) - c_cnt_w'(w_pop);

                if (w_pop) begin
                    r_delay <= w_reload;
                    r_lfsr  <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_lfsr_tp : 16'h0);
                    r_state <= ST_WAIT;
                end else if ((r_state == ST_WAIT) && !w_empty) begin
                    if (r_delay == 32'd0) r_state <= ST_READY;
                    else                  r_delay <= r_delay - 32'd1;
                end
            end
        end
    end

    // At most one channel matches expect_chan_i, so a priority mux is exact.
    always_comb begin
        w_pop_data = '0;
        for (int i = 0; i < channels_p; i++) begin
            if (w_pop_vec[i]) w_pop_data = w_head[i];
        end
    end

    assign w_pop_any         = |w_pop_vec;
    assign w_beat_eq         = (w_pop_data == bus.expect_data_i);
    assign bus.expect_yumi_o = w_pop_any;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_match    <= '0;
            r_mismatch <= '0;
            r_err      <= 1'b0;
        end else if (w_pop_any) begin
            if (w_beat_eq) begin
                if (r_match != '1) r_match <= r_match + 32'd1;
            end else begin
                if (r_mismatch != '1) r_mismatch <= r_mismatch + 32'd1;
                r_err <= 1'b1;
`ifndef SYNTHESIS
                $display("bp_nonsynth_resp_checker: chan=%0d expected=%h actual=%h",
                         bus.expect_chan_i, bus.expect_data_i, w_pop_data);
`endif
            end
        end
    end

`ifdef BP_RESP_CHECKER_WATCHDOG_EN
    logic [31:0] r_wd_cnt;
    logic        r_wd_err;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wd_cnt <= '0;
            r_wd_err <= 1'b0;
        end else if (bus.expect_v_i && !w_pop_any) begin
            if (r_wd_cnt != 32'(timeout_cycles_p)) r_wd_cnt <= r_wd_cnt + 32'd1;
            // Fires on the edge where the count reaches the limit; r_wd_err
            // doubles as the print-once flag.
            if ((r_wd_cnt == 32'(timeout_cycles_p) - 32'd1) && !r_wd_err) begin
                r_wd_err <= 1'b1;
`ifndef SYNTHESIS
                $display("TIMEOUT chan=%0d", bus.expect_chan_i);
`endif
            end
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign w_wd_err = r_wd_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (timeout_cycles_p != 0);
    assign w_wd_err         = 1'b0;
`endif

    assign bus.match_count_o    = r_match;
    assign bus.mismatch_count_o = r_mismatch;
    assign bus.error_o          = r_err | w_wd_err;

endmodule
`default_nettype wire

// File: tb/tb_bp_nonsynth_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_nonsynth_resp_checker
// Purpose  : Directed self-checking bench. Instance A: 4 channels, zero
//            consumer delay. Instance B: 1 channel, delay 2..5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_nonsynth_resp_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_nonsynth_resp_checker_if #(.width_p(32), .channels_p(4)) ifa ();
    bp_nonsynth_resp_checker_if #(.width_p(32), .channels_p(1)) ifb ();

    bp_nonsynth_resp_checker #(
        .width_p(32), .els_p(16), .channels_p(4), .yumi_min_delay_p(0),
        .yumi_max_delay_p(0), .seed_p(16'hACE1), .timeout_cycles_p(64)
    ) dut_a (.clk_i(clk), .reset_i(rst), .bus(ifa.slave));

    bp_nonsynth_resp_checker #(
        .width_p(32), .els_p(16), .channels_p(1), .yumi_min_delay_p(2),
        .yumi_max_delay_p(5), .seed_p(16'hACE1), .timeout_cycles_p(1024)
    ) dut_b (.clk_i(clk), .reset_i(rst), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;
    int exp_match_a = 0;
    int exp_mis_a   = 0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ifa.data_v_i = '0; ifa.data_i = '0; ifa.expect_v_i = 1'b0;
        ifa.expect_data_i = '0; ifa.expect_chan_i = '0;
        ifb.data_v_i = '0; ifb.data_i = '0; ifb.expect_v_i = 1'b0;
        ifb.expect_data_i = '0; ifb.expect_chan_i = '0;
    endtask

    // Presents one beat on channel c of instance A for exactly one cycle.
    task automatic enq_a(input int c, input logic [31:0] v);
        ifa.data_v_i = 4'b0001 << c;
        ifa.data_i = '0;
        ifa.data_i[c*32 +: 32] = v;
        next_cycle();
        ifa.data_v_i = '0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ifa.ready_o !== 4'hF) begin errors++; $display("FAIL reset_ready_a: got %h want f", ifa.ready_o); end
        checks++; if (ifb.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_b: got %b want 1", ifb.ready_o); end
        checks++; if ({ifa.match_count_o, ifa.mismatch_count_o, ifa.error_o, ifa.expect_yumi_o} !== 66'd0) begin
            errors++; $display("FAIL reset_outputs: match=%0d mis=%0d err=%b yumi=%b want all 0",
                ifa.match_count_o, ifa.mismatch_count_o, ifa.error_o, ifa.expect_yumi_o); end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_beat();
        ifa.data_v_i = 4'b0001; ifa.data_i = '0; ifa.data_i[31:0] = 32'h0000_1234;
        next_cycle();
        ifa.data_v_i = '0;
        ifa.expect_v_i = 1'b1; ifa.expect_chan_i = 2'd0; ifa.expect_data_i = 32'h0000_1234;
        @(negedge clk);
        checks++; if (ifa.expect_yumi_o !== 1'b1) begin errors++; $display("FAIL single_yumi: got %b want 1", ifa.expect_yumi_o); end
        next_cycle();
        ifa.expect_v_i = 1'b0;
        exp_match_a++;
        checks++; if (ifa.match_count_o !== 32'(exp_match_a) || ifa.error_o !== 1'b0) begin
            errors++; $display("FAIL single_result: match=%0d err=%b want %0d/0", ifa.match_count_o, ifa.error_o, exp_match_a); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) enq_a(1, 32'd100 + 32'(i));
        @(negedge clk);
        checks++; if (ifa.ready_o !== 4'b1101) begin errors++; $display("FAIL fill_full: ready=%b want 1101", ifa.ready_o); end
        next_cycle();
        enq_a(1, 32'h0000_0BAD);   // rejected: channel 1 is full
        ifa.expect_v_i = 1'b1; ifa.expect_chan_i = 2'd1; ifa.expect_data_i = 32'd100;
        @(negedge clk);
        checks++; if (ifa.expect_yumi_o !== 1'b1 || ifa.ready_o[1] !== 1'b0) begin
            errors++; $display("FAIL fill_first_pop: yumi=%b ready1=%b want 1/0", ifa.expect_yumi_o, ifa.ready_o[1]); end
        next_cycle();
        ifa.expect_v_i = 1'b0;
        checks++; if (ifa.ready_o[1] !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop: got %b want 1", ifa.ready_o[1]); end
        exp_match_a++;
        for (int i = 1; i < 16; i++) begin
            ifa.expect_v_i = 1'b1; ifa.expect_data_i = 32'd100 + 32'(i);
            @(negedge clk);
            checks++; if (ifa.expect_yumi_o !== 1'b1) begin errors++; $display("FAIL fill_drain_%0d: yumi=%b want 1", i, ifa.expect_yumi_o); end
            next_cycle();
            exp_match_a++;
        end
        ifa.expect_data_i = 32'h0000_0BAD;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++; if (ifa.expect_yumi_o !== 1'b0) begin errors++; $display("FAIL fill_dropped_beat: yumi=%b want 0", ifa.expect_yumi_o); end
        next_cycle();
        ifa.expect_v_i = 1'b0;
        checks++; if (ifa.match_count_o !== 32'(exp_match_a) || ifa.mismatch_count_o !== 32'(exp_mis_a)) begin
            errors++; $display("FAIL fill_counts: match=%0d mis=%0d want %0d/%0d",
                ifa.match_count_o, ifa.mismatch_count_o, exp_match_a, exp_mis_a); end
    endtask

    task automatic test_mismatch();
        enq_a(3, 32'hDEAD_BEEF);
        ifa.expect_v_i = 1'b1; ifa.expect_chan_i = 2'd3; ifa.expect_data_i = 32'hDEAD_BEEE;
        next_cycle();
        ifa.expect_v_i = 1'b0;
        exp_mis_a++;
        checks++; if (ifa.mismatch_count_o !== 32'(exp_mis_a) || ifa.error_o !== 1'b1) begin
            errors++; $display("FAIL mismatch_detect: mis=%0d err=%b want %0d/1", ifa.mismatch_count_o, ifa.error_o, exp_mis_a); end
        enq_a(3, 32'h0000_5555);
        ifa.expect_v_i = 1'b1; ifa.expect_data_i = 32'h0000_5555;
        next_cycle();
        ifa.expect_v_i = 1'b0;
        exp_match_a++;
        repeat (2) next_cycle();
        checks++; if (ifa.match_count_o !== 32'(exp_match_a) || ifa.mismatch_count_o !== 32'(exp_mis_a) || ifa.error_o !== 1'b1) begin
            errors++; $display("FAIL mismatch_sticky: match=%0d mis=%0d err=%b want %0d/%0d/1",
                ifa.match_count_o, ifa.mismatch_count_o, ifa.error_o, exp_match_a, exp_mis_a); end
    endtask

    task automatic test_multichan();
        logic seen;
        enq_a(0, 32'h0000_A0A0);
        ifa.expect_v_i = 1'b1; ifa.expect_chan_i = 2'd2; ifa.expect_data_i = 32'h0000_C2C2;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | ifa.expect_yumi_o;
            next_cycle();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL multi_early_pop: yumi seen=%b want 0", seen); end
        ifa.data_v_i = 4'b0100; ifa.data_i = '0; ifa.data_i[64 +: 32] = 32'h0000_C2C2;
        @(negedge clk);
        checks++; if (ifa.expect_yumi_o !== 1'b0) begin errors++; $display("FAIL multi_enq_cycle: yumi=%b want 0", ifa.expect_yumi_o); end
        next_cycle();
        ifa.data_v_i = '0;
        @(negedge clk);
        checks++; if (ifa.expect_yumi_o !== 1'b1) begin errors++; $display("FAIL multi_chan2_pop: yumi=%b want 1", ifa.expect_yumi_o); end
        next_cycle();
        exp_match_a++;
        ifa.expect_chan_i = 2'd0; ifa.expect_data_i = 32'h0000_A0A0;
        @(negedge clk);
        checks++; if (ifa.expect_yumi_o !== 1'b1) begin errors++; $display("FAIL multi_chan0_pop: yumi=%b want 1", ifa.expect_yumi_o); end
        next_cycle();
        ifa.expect_v_i = 1'b0;
        exp_match_a++;
        checks++; if (ifa.match_count_o !== 32'(exp_match_a) || ifa.mismatch_count_o !== 32'(exp_mis_a)) begin
            errors++; $display("FAIL multi_counts: match=%0d mis=%0d want %0d/%0d",
                ifa.match_count_o, ifa.mismatch_count_o, exp_match_a, exp_mis_a); end
    endtask

    task automatic test_random_delay();
        int sent = 0, popped = 0, occ = 0, gap = 0, exp_gap = 2, budget = 0;
        logic [15:0] lfsr = 16'hACE1;
        logic nonempty, rdy, yumi;
        while (popped < 100 && budget < 3000) begin
            ifb.data_v_i      = (sent < 100) ? 1'b1 : 1'b0;
            ifb.data_i        = 32'h1000_0000 + 32'(sent) * 32'd7;
            ifb.expect_v_i    = 1'b1;
            ifb.expect_chan_i = 1'b0;
            ifb.expect_data_i = 32'h1000_0000 + 32'(popped) * 32'd7;
            @(negedge clk);
            nonempty = (occ > 0);
            rdy  = ifb.ready_o;
            yumi = ifb.expect_yumi_o;
            if (yumi) begin
                checks++;
                if (!nonempty || gap != exp_gap) begin
                    errors++; $display("FAIL random_gap_%0d: gap=%0d nonempty=%b want gap %0d", popped, gap, nonempty, exp_gap);
                end
                exp_gap = 2 + int'(lfsr % 16'd4);
                lfsr = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0);
                gap = 0;
                popped++;
                occ--;
            end else if (nonempty) begin
                gap++;
            end
            if (ifb.data_v_i && rdy) begin sent++; occ++; end
            budget++;
            next_cycle();
        end
        ifb.data_v_i = 1'b0; ifb.expect_v_i = 1'b0;
        if (popped < 100) begin
            errors++; $display("FAIL random_timeout: popped=%0d want 100", popped);
        end
        next_cycle();
        checks++; if (ifb.match_count_o !== 32'd100 || ifb.mismatch_count_o !== 32'd0 || ifb.error_o !== 1'b0) begin
            errors++; $display("FAIL random_counts: match=%0d mis=%0d err=%b want 100/0/0",
                ifb.match_count_o, ifb.mismatch_count_o, ifb.error_o); end
    endtask

    task automatic test_reset_midstream();
        logic seen;
        for (int i = 0; i < 5; i++) enq_a(i % 4, 32'h0000_7700 + 32'(i));
        #2 rst = 1'b1;
        #1;
        checks++; if (ifa.ready_o !== 4'hF || ifa.match_count_o !== 32'd0 || ifa.mismatch_count_o !== 32'd0 || ifa.error_o !== 1'b0) begin
            errors++; $display("FAIL midreset_state: ready=%h match=%0d mis=%0d err=%b want f/0/0/0",
                ifa.ready_o, ifa.match_count_o, ifa.mismatch_count_o, ifa.error_o); end
        next_cycle();
        rst = 1'b0;
        ifa.expect_v_i = 1'b1; ifa.expect_chan_i = 2'd0; ifa.expect_data_i = 32'h0000_7700;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | ifa.expect_yumi_o;
            next_cycle();
        end
        ifa.expect_v_i = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_discard: yumi seen=%b want 0", seen); end
    endtask

`ifdef BP_RESP_CHECKER_WATCHDOG_EN
    task automatic test_watchdog();
        rst = 1'b1; next_cycle(); rst = 1'b0; next_cycle();
        ifa.expect_v_i = 1'b1; ifa.expect_chan_i = 2'd1; ifa.expect_data_i = '0;
        repeat (63) next_cycle();
        checks++; if (ifa.error_o !== 1'b0) begin errors++; $display("FAIL watchdog_early: err=%b want 0", ifa.error_o); end
        next_cycle();
        checks++; if (ifa.error_o !== 1'b1) begin errors++; $display("FAIL watchdog_fire: err=%b want 1", ifa.error_o); end
        ifa.expect_v_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_fill();
        test_mismatch();
        test_multichan();
        test_random_delay();
        test_reset_midstream();
`ifdef BP_RESP_CHECKER_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bp_nonsynth_resp_checker.md
Name: bp_nonsynth_resp_checker

Overview:
- Multi-channel response buffer and in-order checker for FE/ME cache unit benches.
- Each channel has a small FIFO that absorbs DUT response beats. A per-channel LFSR-driven random-delay consumer drains the FIFO.
- Each popped beat is compared against an expected-value stream from trace replay. Match and mismatch counts and a sticky error are reported.
- Sits between the DUT data outputs and the trace-replay engine; replaces the single fixed FIFO plus random-yumi pair.

Parameters:
- width_p, 32, data width per beat.
- els_p, 16, FIFO depth per channel; power of 2, >=2.
- channels_p, 1, number of independent response channels; >=1.
- yumi_min_delay_p, 0, minimum consumer delay in cycles.
- yumi_max_delay_p, 15, maximum consumer delay in cycles; must be >= min.
- seed_p, 16'hACE1, LFSR seed; channel c uses seed_p ^ c. A seed of 0 is forced to 1.
- timeout_cycles_p, 1024, watchdog limit (optional feature only).

Ports:
- clk_i, in, 1, clock.
- reset_i, in, 1, asynchronous active-high reset.
- data_v_i, in, channels_p, per-channel DUT beat valid.
- data_i, in, channels_p*width_p, per-channel beat; channel c occupies [c*width_p+:width_p].
- ready_o, out, channels_p, per-channel FIFO not full.
- expect_v_i, in, 1, expected beat valid.
- expect_data_i, in, width_p, expected beat value.
- expect_chan_i, in, max(1,$clog2(channels_p)), target channel of the expected beat.
- expect_yumi_o, out, 1, expected beat consumed this cycle.
- match_count_o, out, 32, total matched beats.
- mismatch_count_o, out, 32, total mismatched beats.
- error_o, out, 1, sticky error flag.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - FIFOs empty, so ready_o = all 1s.
  - expect_yumi_o = 0, both counts = 0, error_o = 0.
  - LFSRs reloaded with seeds; delay counters loaded with yumi_min_delay_p.
  - Reset mid-operation discards all buffered beats and all state.
- Enqueue:
  - Channel c enqueues data_i slice c when data_v_i[c] & ready_o[c].
  - ready_o[c] depends only on registered occupancy; it is 0 when occupancy == els_p.
  - No bypass: a full FIFO rejects the beat even if a pop happens in the same cycle.
  - data_v_i[c] asserted while ready_o[c]=0 is dropped by the sender's own handshake rule; the checker does not record it.
- FIFO:
  - Read/write pointers wrap modulo els_p; occupancy counter width is $clog2(els_p)+1.
  - Simultaneous enqueue and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
  - First-word latency is 1 cycle: a beat enqueued in cycle N is poppable in cycle N+1 at the earliest.
- Consumer, per channel, 2 states:
  - WAIT: the delay counter decrements each cycle the FIFO is non-empty, saturating at 0. Go to READY when the counter is 0 and the FIFO is non-empty.
  - READY: pop when expect_v_i & expect_chan_i == c. In that case expect_yumi_o = 1, the LFSR steps, the counter reloads, and the state returns to WAIT. Otherwise stay in READY.
- Delay reload value = yumi_min_delay_p + (lfsr % (yumi_max_delay_p - yumi_min_delay_p + 1)).
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1; steps only on a pop.
- expect_yumi_o is combinational from state, expect_v_i and expect_chan_i. At most one channel pops per cycle by construction.
- expect_chan_i >= channels_p never pops; expect_v_i simply stays pending.
- Compare on each pop, registered 1 cycle after the pop:
  - Equal beat: match_count_o += 1.
  - Unequal beat: mismatch_count_o += 1, error_o is set, and $display prints channel, expected and actual values.
  - Both counters saturate at 32'hFFFF_FFFF.
  - error_o clears only on reset.

Optional Feature:
- Macro: BP_RESP_CHECKER_WATCHDOG_EN.
- Defined:
  - A 32-bit counter increments each cycle expect_v_i=1 & expect_yumi_o=0, and clears on expect_yumi_o or when expect_v_i=0.
  - When the counter reaches timeout_cycles_p, error_o is set (sticky) and "TIMEOUT chan=<c>" is displayed once.
- Undefined: no counter is instantiated; error_o is driven only by mismatches; timeout_cycles_p is ignored.

Test Plan:
- Single beat, channels_p=1, min=max=0: enqueue 32'h0000_1234, then expect_v_i with 32'h0000_1234 → expect_yumi_o=1 in the cycle after the enqueue; match_count_o=1 and error_o=0 one cycle later.
- Fill to full, els_p=16, expect_v_i=0: 16 beats enqueued → ready_o=0. Then 17th data_v_i, then one pop → ready_o=1 the cycle after the pop; the 17th beat is absent from the compared stream.
- Mismatch: enqueue 32'hDEAD_BEEF, expect 32'hDEAD_BEEE → mismatch_count_o=1, error_o=1 and held; next matching beat → match_count_o=1, error_o still 1.
- Random delay, min=2, max=5: 100 beats → every pop occurs 2..5 FIFO-non-empty cycles after the previous pop or reset; match_count_o=100.
- Multi-channel, channels_p=4: interleaved expects for channel 2 then channel 0 → channel 2 pops only after its own beat arrives; channel 0's beat waits without popping; neither channel pops out of order.
- Reset mid-stream after 5 buffered beats → ready_o=4'hF, both counts 0, error_o=0 immediately. With BP_RESP_CHECKER_WATCHDOG_EN and timeout_cycles_p=64: expect_v_i held for 64 cycles on an empty channel → error_o=1.
